// File: rtl/scurve_test_control.sv
// Threshold-DAC / channel sweep sequencer feeding the single-channel S-curve counter stage.
// Define SCURVE_TAIL_WORD_EN to append a 16'hFF45 tail word after a completed sweep.
module scurve_test_control #(
  parameter int DAC_WIDTH = 10,
  parameter int CHN_NUM   = 64
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  input  logic                 Test_Start,
  input  logic                 Single_Chn_Mode,
  input  logic [5:0]           Single_Chn,
  input  logic [DAC_WIDTH-1:0] Start_Dac,
  input  logic [DAC_WIDTH-1:0] End_Dac,
  input  logic [DAC_WIDTH-1:0] Dac_Step,
  input  logic                 Config_Done,
  input  logic                 One_Channel_Done,
  output logic                 Config_Start,
  output logic [DAC_WIDTH-1:0] Dac_Code,
  output logic [CHN_NUM-1:0]   Chn_Mask,
  output logic                 SCurve_Test_Start,
  output logic [15:0]          Header_Data,
  output logic                 Header_wr_en,
  output logic                 Busy,
  output logic                 Sweep_Done
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    CFG_LOAD    = 4'd1,
    CFG_WAIT    = 4'd2,
    HEADER      = 4'd3,
    START_POINT = 4'd4,
    WAIT_POINT  = 4'd5,
    NEXT_DAC    = 4'd6,
    NEXT_CHN    = 4'd7,
    TAIL        = 4'd8,
    DONE        = 4'd9
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 test_start_q;
  logic                 start;
  logic                 abort;
  logic [5:0]           chn;
  logic [5:0]           chn_next;
  logic [DAC_WIDTH-1:0] dac;
  logic [DAC_WIDTH-1:0] dac_next;
  logic [DAC_WIDTH-1:0] start_l;
  logic [DAC_WIDTH-1:0] end_l;
  logic [DAC_WIDTH-1:0] step_l;
  logic                 mode_l;
  logic [DAC_WIDTH:0]   sum;

  assign start = Test_Start & ~test_start_q;
  assign abort = ~test_start_q;

  // State register
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Channel/DAC counters, Test_Start edge register and sweep-setting latches
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      test_start_q <= 1'b0;
      chn          <= 6'd0;
      dac          <= '0;
      start_l      <= '0;
      end_l        <= '0;
      step_l       <= '0;
      mode_l       <= 1'b0;
    end else begin
      test_start_q <= Test_Start;
      chn          <= chn_next;
      dac          <= dac_next;
      if (state == IDLE && start) begin
        start_l <= Start_Dac;
        end_l   <= End_Dac;
        step_l  <= (Dac_Step == '0) ? {{(DAC_WIDTH-1){1'b0}}, 1'b1} : Dac_Step;
        mode_l  <= Single_Chn_Mode;
      end
    end
  end

  // Next-state and next channel/DAC selection
  always_comb begin
    state_next = state;
    chn_next   = chn;
    dac_next   = dac;
    sum        = {1'b0, dac} + {1'b0, step_l};
    case (state)
      IDLE: begin
        if (start) begin
          chn_next   = Single_Chn_Mode ? Single_Chn : 6'd0;
          dac_next   = Start_Dac;
          state_next = CFG_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      CFG_LOAD:    state_next = abort ? IDLE : CFG_WAIT;
      CFG_WAIT: begin
        if (Config_Done) begin
          state_next = abort ? IDLE : HEADER;
        end else begin
          state_next = CFG_WAIT;
        end
      end
      HEADER:      state_next = abort ? IDLE : START_POINT;
      START_POINT: state_next = abort ? IDLE : WAIT_POINT;
      // An abort here still lets the counter stage finish its point
      WAIT_POINT: begin
        if (One_Channel_Done) begin
          state_next = abort ? IDLE : NEXT_DAC;
        end else begin
          state_next = WAIT_POINT;
        end
      end
      NEXT_DAC: begin
        if (abort) begin
          state_next = IDLE;
        end else if (sum[DAC_WIDTH] || (sum[DAC_WIDTH-1:0] > end_l) || (start_l > end_l)) begin
          state_next = NEXT_CHN;
        end else begin
          dac_next   = sum[DAC_WIDTH-1:0];
          state_next = CFG_LOAD;
        end
      end
      NEXT_CHN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (mode_l || (chn == 6'(CHN_NUM - 1))) begin
`ifdef SCURVE_TAIL_WORD_EN
          state_next = TAIL;
`else
          state_next = DONE;
`endif
        end else begin
          chn_next   = chn + 6'd1;
          dac_next   = start_l;
          state_next = CFG_LOAD;
        end
      end
      TAIL:        state_next = abort ? IDLE : DONE;
      DONE:        state_next = abort ? IDLE : DONE;
      default:     state_next = IDLE;
    endcase
  end

  // Registered outputs, decoded from the state being entered so they align with it
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      Config_Start      <= 1'b0;
      Dac_Code          <= '0;
      Chn_Mask          <= '0;
      SCurve_Test_Start <= 1'b0;
      Header_Data       <= 16'd0;
      Header_wr_en      <= 1'b0;
      Busy              <= 1'b0;
      Sweep_Done        <= 1'b0;
    end else begin
      Config_Start      <= (state_next == CFG_LOAD);
      SCurve_Test_Start <= (state_next == START_POINT);
      Header_wr_en      <= (state_next == HEADER) || (state_next == TAIL);
      Busy              <= (state_next != IDLE) && (state_next != DONE);
      Sweep_Done        <= (state_next == DONE);
      if (state_next == CFG_LOAD) begin
        Dac_Code <= dac_next;
        Chn_Mask <= {{(CHN_NUM-1){1'b0}}, 1'b1} << chn_next;
      end
      if (state_next == HEADER) begin
        Header_Data <= {chn, 10'(dac)};
      end else if (state_next == TAIL) begin
        Header_Data <= 16'hFF45;
      end
    end
  end

endmodule

// File: tb/tb_scurve_test_control.sv
// Self-checking bench for scurve_test_control: vector table of sweeps, header scoreboard,
// Config_Done / One_Channel_Done responder, plus abort and mid-sweep reset sequences.
module tb_scurve_test_control;
  localparam int DW = 10;
  localparam int CN = 64;
`ifdef SCURVE_TAIL_WORD_EN
  localparam int TAIL_N = 1;
`else
  localparam int TAIL_N = 0;
`endif

  logic          Clk = 1'b0;
  logic          reset_n;
  logic          Test_Start;
  logic          Single_Chn_Mode;
  logic [5:0]    Single_Chn;
  logic [DW-1:0] Start_Dac;
  logic [DW-1:0] End_Dac;
  logic [DW-1:0] Dac_Step;
  logic          Config_Done;
  logic          One_Channel_Done;
  logic          Config_Start;
  logic [DW-1:0] Dac_Code;
  logic [CN-1:0] Chn_Mask;
  logic          SCurve_Test_Start;
  logic [15:0]   Header_Data;
  logic          Header_wr_en;
  logic          Busy;
  logic          Sweep_Done;

  always #5 Clk = ~Clk;

  scurve_test_control #(.DAC_WIDTH(DW), .CHN_NUM(CN)) dut (
    .Clk(Clk), .reset_n(reset_n), .Test_Start(Test_Start),
    .Single_Chn_Mode(Single_Chn_Mode), .Single_Chn(Single_Chn),
    .Start_Dac(Start_Dac), .End_Dac(End_Dac), .Dac_Step(Dac_Step),
    .Config_Done(Config_Done), .One_Channel_Done(One_Channel_Done),
    .Config_Start(Config_Start), .Dac_Code(Dac_Code), .Chn_Mask(Chn_Mask),
    .SCurve_Test_Start(SCurve_Test_Start), .Header_Data(Header_Data),
    .Header_wr_en(Header_wr_en), .Busy(Busy), .Sweep_Done(Sweep_Done)
  );

  typedef struct {
    logic       mode;
    logic [5:0] chn;
    logic [9:0] sd;
    logic [9:0] ed;
    logic [9:0] st;
    int         pts;
  } vec_t;

  vec_t        vecs[7];
  logic [16:0] exp_q[$];   // {is_tail, header}
  int checks = 0;
  int errors = 0;
  int cfg_cnt = 0, stp_cnt = 0, hdr_cnt = 0, done_rise = 0;
  int cfg_dly = 0, ocd_dly = 0;
  logic cfg_en = 1'b1, ocd_en = 1'b1, inj_cfg = 1'b0, inj_ocd = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Slow-control loader and counter-stage responder
  initial begin
    Config_Done = 1'b0;
    One_Channel_Done = 1'b0;
    forever begin
      @(negedge Clk);
      Config_Done      = (cfg_dly == 1) | inj_cfg;
      One_Channel_Done = (ocd_dly == 1) | inj_ocd;
      if (cfg_dly > 0) cfg_dly--;
      if (ocd_dly > 0) ocd_dly--;
      if (Config_Start && cfg_en) cfg_dly = 2;
      if (SCurve_Test_Start && ocd_en) ocd_dly = 4;
    end
  end

  // Output monitor and header scoreboard
  initial begin : mon
    logic        stp_prev, sd_prev, wr_prev;
    logic [15:0] data_prev;
    logic [16:0] e;
    stp_prev = 1'b0; sd_prev = 1'b0; wr_prev = 1'b0; data_prev = 16'd0;
    forever begin
      @(negedge Clk);
      if (Config_Start) cfg_cnt++;
      if (SCurve_Test_Start) begin
        stp_cnt++;
        check("stp_pulse_width", {63'd0, stp_prev}, 64'd0);
      end
      if (Header_wr_en) begin
        hdr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_header actual=%0h expected=none", Header_Data);
        end else begin
          e = exp_q.pop_front();
          check("header", {48'd0, Header_Data}, {48'd0, e[15:0]});
          if (!e[16]) begin
            check("chn_mask", Chn_Mask, 64'd1 << e[15:10]);
            check("dac_code", {54'd0, Dac_Code}, {54'd0, e[9:0]});
          end
        end
      end
      if (Sweep_Done && !sd_prev) begin
        done_rise++;
`ifdef SCURVE_TAIL_WORD_EN
        check("tail_before_done", {47'd0, wr_prev, data_prev}, {47'd0, 1'b1, 16'hFF45});
`else
        check("no_tail_before_done", {63'd0, wr_prev}, 64'd0);
`endif
      end
      stp_prev  = SCurve_Test_Start;
      sd_prev   = Sweep_Done;
      wr_prev   = Header_wr_en;
      data_prev = Header_Data;
    end
  end

  task automatic run_vec(input vec_t v);
    int eff, n, c0, s0, h0, d0, k;
    logic [5:0] ch;
    eff = (v.st == 10'd0) ? 1 : int'(v.st);
    n = 0;
    for (int c = 0; c < (v.mode ? 1 : CN); c++) begin
      ch = v.mode ? v.chn : 6'(c);
      if (v.sd > v.ed) begin
        exp_q.push_back({1'b0, ch, v.sd});
        n++;
      end else begin
        for (int d = int'(v.sd); d <= int'(v.ed); d += eff) begin
          exp_q.push_back({1'b0, ch, 10'(d)});
          n++;
        end
      end
    end
    if (TAIL_N == 1) exp_q.push_back({1'b1, 16'hFF45});
    c0 = cfg_cnt; s0 = stp_cnt; h0 = hdr_cnt; d0 = done_rise;
    Single_Chn_Mode = v.mode; Single_Chn = v.chn;
    Start_Dac = v.sd; End_Dac = v.ed; Dac_Step = v.st;
    Test_Start = 1'b1;
    repeat (3) @(negedge Clk);
    // Settings are latched at start; scramble them to prove it
    Single_Chn_Mode = 1'($urandom); Single_Chn = 6'($urandom);
    Start_Dac = 10'($urandom); End_Dac = 10'($urandom); Dac_Step = 10'($urandom);
    k = 0;
    while (!Sweep_Done && k < 6000) begin
      @(negedge Clk);
      k++;
    end
    check("sweep_done", {63'd0, Sweep_Done}, 64'd1);
    check("busy_in_done", {63'd0, Busy}, 64'd0);
    check("cfg_pulses", 64'(cfg_cnt - c0), 64'(v.pts));
    check("stp_pulses", 64'(stp_cnt - s0), 64'(v.pts));
    check("hdr_writes", 64'(hdr_cnt - h0), 64'(v.pts + TAIL_N));
    check("model_points", 64'(n), 64'(v.pts));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_rises", 64'(done_rise - d0), 64'd1);
    Test_Start = 1'b0;
    repeat (2) @(negedge Clk);
    check("done_cleared", {63'd0, Sweep_Done}, 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int c0, s0, h0, d0, k;
    vecs[0] = '{1'b1, 6'd5,  10'd100,  10'd104,  10'd2,    3};
    vecs[1] = '{1'b0, 6'd0,  10'd200,  10'd200,  10'd1,    64};
    vecs[2] = '{1'b1, 6'd7,  10'd1020, 10'd1023, 10'd4,    1};
    vecs[3] = '{1'b1, 6'd0,  10'd10,   10'd12,   10'd0,    3};
    vecs[4] = '{1'b1, 6'd63, 10'd50,   10'd40,   10'd3,    1};
    vecs[5] = '{1'b0, 6'd0,  10'd50,   10'd40,   10'd1,    64};
    vecs[6] = '{1'b1, 6'd9,  10'd1023, 10'd1023, 10'd1,    1};

    reset_n = 1'b0; Test_Start = 1'b0; Single_Chn_Mode = 1'b0; Single_Chn = 6'd0;
    Start_Dac = 10'd0; End_Dac = 10'd0; Dac_Step = 10'd0;
    repeat (3) @(negedge Clk);
    check("rst_outputs", {Config_Start, SCurve_Test_Start, Header_wr_en, Busy, Sweep_Done,
                          Header_Data, Dac_Code}, 64'd0);
    check("rst_mask", Chn_Mask, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Stray done pulses in IDLE must be ignored
    inj_cfg = 1'b1; inj_ocd = 1'b1;
    @(negedge Clk);
    inj_cfg = 1'b0; inj_ocd = 1'b0;
    repeat (3) @(negedge Clk);
    check("idle_stray_busy", {63'd0, Busy}, 64'd0);
    check("idle_stray_cfg", 64'(cfg_cnt), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Abort during WAIT_POINT of the second point
    exp_q.push_back({1'b0, 6'd3, 10'd0});
    exp_q.push_back({1'b0, 6'd3, 10'd1});
    c0 = cfg_cnt; s0 = stp_cnt; h0 = hdr_cnt; d0 = done_rise;
    Single_Chn_Mode = 1'b1; Single_Chn = 6'd3; Start_Dac = 10'd0; End_Dac = 10'd20; Dac_Step = 10'd1;
    Test_Start = 1'b1;
    k = 0;
    while ((stp_cnt - s0) < 2 && k < 500) begin
      @(negedge Clk);
      k++;
    end
    check("abort_reached_pt2", 64'(stp_cnt - s0), 64'd2);
    Test_Start = 1'b0;
    repeat (2) @(negedge Clk);
    check("abort_still_waiting", {63'd0, Busy}, 64'd1);
    repeat (30) @(negedge Clk);
    check("abort_cfg_pulses", 64'(cfg_cnt - c0), 64'd2);
    check("abort_hdr_writes", 64'(hdr_cnt - h0), 64'd2);
    check("abort_no_done", 64'(done_rise - d0), 64'd0);
    check("abort_idle", {62'd0, Busy, Sweep_Done}, 64'd0);
    exp_q.delete();

    // Asynchronous reset while stuck in CFG_WAIT
    cfg_en = 1'b0;
    c0 = cfg_cnt;
    Single_Chn_Mode = 1'b1; Single_Chn = 6'd12; Start_Dac = 10'd300; End_Dac = 10'd310; Dac_Step = 10'd1;
    Test_Start = 1'b1;
    k = 0;
    while (cfg_cnt == c0 && k < 50) begin
      @(negedge Clk);
      k++;
    end
    repeat (3) @(negedge Clk);
    check("cfgwait_busy", {63'd0, Busy}, 64'd1);
    check("cfgwait_dac", {54'd0, Dac_Code}, 64'd300);
    check("cfgwait_mask", Chn_Mask, 64'd1 << 12);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_outputs", {Config_Start, SCurve_Test_Start, Header_wr_en, Busy, Sweep_Done,
                             Header_Data, Dac_Code}, 64'd0);
    check("midrst_mask", Chn_Mask, 64'd0);
    Test_Start = 1'b0;
    @(negedge Clk);
    reset_n = 1'b1;
    cfg_en = 1'b1;
    repeat (3) @(negedge Clk);
    check("post_rst_idle", {63'd0, Busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scurve_test_control.md
Name: scurve_test_control

Overview:
- Sweep sequencer that sits directly upstream of the single-channel S-curve counter stage. It walks the threshold DAC code from Start_Dac to End_Dac in Dac_Step increments, for either one selected channel or all CHN_NUM channels.
- For each (channel, DAC) point it:
  - requests an ASIC slow-control reload,
  - writes a 16-bit header word into the shared S-curve data FIFO,
  - pulses SCurve_Test_Start,
  - waits for One_Channel_Done.
- The downstream counter stage's six count words follow each header in the FIFO.

Parameters:
- DAC_WIDTH, 10, width of threshold DAC code.
- CHN_NUM, 64, number of channels swept in all-channel mode; channel index width is 6.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Test_Start  in  1  host level; rising edge starts a sweep; low aborts.
- Single_Chn_Mode  in  1  1 = sweep Single_Chn only; 0 = channels 0..CHN_NUM-1.
- Single_Chn  in  6  channel used in single mode.
- Start_Dac  in  DAC_WIDTH  first DAC code.
- End_Dac  in  DAC_WIDTH  last DAC code (inclusive bound).
- Dac_Step  in  DAC_WIDTH  DAC increment; 0 is treated as 1.
- Config_Done  in  1  one-cycle pulse from the slow-control loader.
- One_Channel_Done  in  1  one-cycle pulse from the counter stage.
- Config_Start  out  1  one-cycle pulse requesting a slow-control reload.
- Dac_Code  out  DAC_WIDTH  current threshold code; stable from Config_Start until the next one.
- Chn_Mask  out  CHN_NUM  one-hot ctest/trigger-enable mask of the current channel.
- SCurve_Test_Start  out  1  one-cycle start pulse to the counter stage.
- Header_Data  out  16  {channel[5:0], Dac_Code[9:0]}.
- Header_wr_en  out  1  one-cycle FIFO write strobe.
- Busy  out  1  high whenever the state is not IDLE and not DONE.
- Sweep_Done  out  1  level; high in DONE.

Behaviour:
- Reset (async, active-low): all outputs 0, state IDLE, channel and DAC registers 0.
- Test_Start is registered once; start = registered-low & current-high (rising edge).
- Input latching: Start_Dac, End_Dac, Dac_Step, Single_Chn_Mode and Single_Chn are latched at start and ignored afterwards.
- States:
  - IDLE: on start, channel <= (mode ? Single_Chn : 0), dac <= Start_Dac, go to CFG_LOAD.
  - CFG_LOAD: Dac_Code <= dac, Chn_Mask <= 1<<channel, Config_Start = 1 for one cycle, go to CFG_WAIT.
  - CFG_WAIT: wait for Config_Done; no timeout; then go to HEADER.
  - HEADER: Header_Data <= {channel, dac}, Header_wr_en = 1 for one cycle, go to START_POINT.
  - START_POINT: SCurve_Test_Start = 1 for exactly one cycle, go to WAIT_POINT. It must be a pulse; a held level would re-trigger the counter stage once it returns to its idle state.
  - WAIT_POINT: wait for One_Channel_Done, then go to NEXT_DAC.
  - NEXT_DAC: sum = dac + max(Dac_Step,1), computed DAC_WIDTH+1 bits wide.
    - If carry out, or sum > End_Dac, or Start_Dac > End_Dac: go to NEXT_CHN.
    - Otherwise dac <= sum[DAC_WIDTH-1:0] and go to CFG_LOAD.
  - NEXT_CHN:
    - If single mode, or channel == CHN_NUM-1: go to DONE.
    - Otherwise channel++, dac <= Start_Dac, go to CFG_LOAD.
  - DONE: Sweep_Done = 1 and held; on Test_Start low, clear Sweep_Done and go to IDLE.
- Start_Dac > End_Dac: exactly one point at Start_Dac per channel.
- Abort (registered Test_Start low, in any state other than IDLE or DONE):
  - WAIT_POINT: keep waiting for One_Channel_Done, then go to IDLE. The counter stage's six words are still written.
  - CFG_WAIT: wait for Config_Done, then go to IDLE.
  - Any other state: go to IDLE next cycle.
  - Sweep_Done is never set on abort. A restart needs a new rising edge.
- Unexpected pulses: One_Channel_Done or Config_Done outside their wait states are ignored.
- Points per channel: floor((End_Dac-Start_Dac)/step)+1 when Start_Dac <= End_Dac.

Optional Feature:
- Macro SCURVE_TAIL_WORD_EN.
  - Defined: on the NEXT_CHN -> DONE transition, emit one extra write with Header_Data = 16'hFF45 and Header_wr_en = 1 for one cycle, one cycle before Sweep_Done rises.
  - Undefined: no tail word; Sweep_Done rises the cycle after NEXT_CHN.
  - Abort never emits the tail word.

Test Plan:
- Single mode, chn 5, Start 100, End 104, Step 2:
  - headers 0x1464, 0x1466, 0x1468 (chn 5 = 000101, DAC 100/102/104);
  - 3 Config_Start pulses, 3 SCurve_Test_Start pulses, then Sweep_Done = 1.
- All-channel mode, Start = End = 200, Step 1, with a responder model:
  - 64 headers, channel field 0..63, DAC 200;
  - Chn_Mask one-hot matches each header;
  - Sweep_Done after the 64th One_Channel_Done.
- Start 1020, End 1023, Step 4:
  - single point 1020; carry/over-bound exits with no wrap to 0.
- Step 0, Start 10, End 12:
  - treated as step 1; headers DAC 10, 11, 12.
- Start 50, End 40:
  - one point at 50 per channel.
- Test_Start dropped during WAIT_POINT of the 2nd point:
  - the controller waits for One_Channel_Done, returns to IDLE, and no further Config_Start follows;
  - Sweep_Done stays 0;
  - reset_n asserted mid-CFG_WAIT clears all outputs immediately.
- With SCURVE_TAIL_WORD_EN:
  - the last write before Sweep_Done is 0xFF45;
  - the tail word is absent when the macro is undefined or on abort.
